// File: rtl/fan_start_scheduler.sv
// rtl/fan_start_scheduler.sv - staggers fan start pulses on N channels so only one begins per slot,
// with a per-channel rearm window and a sticky flag for requests that waited too long.
module fan_start_scheduler #(
  parameter int CLKDIV     = 50,
  parameter int N          = 4,
  parameter int PWM_LENGTH = 1900,
  parameter int PWM_REARM  = 7600,
  parameter int START_GAP  = 200,
  parameter int MAX_WAIT   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pwm_i,
  input  logic         clr_ovr,
  output logic [N-1:0] pwm_o,
  output logic [N-1:0] overrun_o,
  output logic         busy_o
);

  localparam int DW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int CMAX = (PWM_LENGTH + PWM_REARM > MAX_WAIT) ? PWM_LENGTH + PWM_REARM : MAX_WAIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam int RW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(START_GAP - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(PWM_LENGTH - 1);
  localparam logic [CW-1:0] RUN_END   = CW'(PWM_LENGTH);
  localparam logic [CW-1:0] STOP_LAST = CW'(PWM_LENGTH + PWM_REARM - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [RW-1:0] IDX_LAST  = RW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [N-1:0]  ovr_q, ovr_d;
  logic [3:0]    sh_q [N];
  logic [3:0]    sh_d [N];
  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  logic          grant_valid;
  logic [RW-1:0] grant_idx;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    tick_d = (div_q == DIV_LAST);
  end

  // Round-robin search starting at rr_q; only channels already in WAIT are eligible.
  always_comb begin : grant_search
    logic [RW-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    if (tick_q && gap_q == '0) begin
      for (int i = 0; i < N; i++) begin
        idx = RW'((int'(rr_q) + i) % N);
        if (!grant_valid && state_q[idx] == S_WAIT) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    gap_d = gap_q;
    rr_d  = rr_q;
    if (tick_q) begin
      if (grant_valid) begin
        gap_d = GAP_LOAD;
        rr_d  = (grant_idx == IDX_LAST) ? '0 : grant_idx + RW'(1);
      end else if (gap_q != '0) begin
        gap_d = gap_q - GW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      sh_d[k]    = sh_q[k];
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      ovr_d[k]   = clr_ovr ? 1'b0 : ovr_q[k];
      if (tick_q) begin
        sh_d[k] = {sh_q[k][2:0], pwm_i[k]};
        case (state_q[k])
          // sh_q[2:0] are the samples that become the three oldest bits on this shift.
          S_IDLE: begin
            if (sh_q[k][2:0] == 3'b000) begin
              state_d[k] = S_WAIT;
              cnt_d[k]   = '0;
            end
          end
          S_WAIT: begin
            if (grant_valid && grant_idx == RW'(k)) begin
              state_d[k] = S_RUN;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] == WAIT_LAST) begin
              state_d[k] = S_STOP;
              cnt_d[k]   = RUN_END;
              ovr_d[k]   = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          S_RUN: begin
            if (cnt_q[k] == RUN_LAST) state_d[k] = S_STOP;
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
          S_STOP: begin
            if (cnt_q[k] == STOP_LAST) begin
              state_d[k] = S_IDLE;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          default: begin
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      gap_q  <= '0;
      rr_q   <= '0;
      ovr_q  <= '0;
      for (int k = 0; k < N; k++) begin
        sh_q[k]    <= 4'b1111;
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      gap_q  <= gap_d;
      rr_q   <= rr_d;
      ovr_q  <= ovr_d;
      for (int k = 0; k < N; k++) begin
        sh_q[k]    <= sh_d[k];
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      pwm_o[k] = (state_q[k] == S_RUN);
    end
    overrun_o = ovr_q;
    busy_o    = |pwm_o;
  end

endmodule
